// File: rtl/acc_bank_sat_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : acc_bank_sat_if                                                   |
// | Brief  : Beat-in / result-out handshake bundle for the accumulator bank.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface acc_bank_sat_if #(
   parameter int LANES      = 4,
   parameter int BIT_WIDTH  = 12,
   parameter int BIAS_WIDTH = 12,
   parameter int CNT_W      = 6
);
   logic [CNT_W-1:0]             num_chn;
   logic                         relu_en;
   logic                         flush;
   logic                         in_valid;
   logic                         in_ready;
   logic [LANES*BIT_WIDTH-1:0]   x_in;
   logic [LANES*BIAS_WIDTH-1:0]  bias_in;
   logic                         out_valid;
   logic                         out_ready;
   logic [LANES*BIT_WIDTH-1:0]   y_out;
   logic [LANES-1:0]             sat_flag;

   modport master (
      output num_chn, relu_en, flush, in_valid, x_in, bias_in, out_ready,
      input  in_ready, out_valid, y_out, sat_flag
   );

   modport slave (
      input  num_chn, relu_en, flush, in_valid, x_in, bias_in, out_ready,
      output in_ready, out_valid, y_out, sat_flag
   );
endinterface
`default_nettype wire

// File: rtl/acc_bank_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : acc_bank_sat                                                      |
// | Brief  : Multi-lane biased accumulator with rounding shift, saturation     |
// |          and optional ReLU, one registered result per channel group.       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module acc_bank_sat #(
   parameter int LANES      = 4,
   parameter int BIT_WIDTH  = 12,
   parameter int BIAS_WIDTH = 12,
   parameter int CHN_MAX    = 32,
   parameter int ACC_WIDTH  = 18,
   parameter int SHIFT      = 0,
   parameter int CNT_W      = $clog2(CHN_MAX + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   acc_bank_sat_if.slave        bus
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] n_lat;
   logic [CNT_W-1:0] n_in;
   logic [CNT_W-1:0] n_eff;
   logic             relu_lat;
   logic             relu_eff;
   logic             first;
   logic             last;
   logic             stall;
   logic             ready;
   logic             accept;
   logic             load;
   logic             out_valid_q;

   // The first beat uses the live num_chn/relu_en so a one-beat group can complete at once.
   always_comb begin
      n_in = bus.num_chn;
      if (bus.num_chn == '0)
         n_in = CNT_W'(1);
      else if (bus.num_chn > CNT_W'(CHN_MAX))
         n_in = CNT_W'(CHN_MAX);
      first    = (cnt == '0);
      n_eff    = first ? n_in : n_lat;
      relu_eff = first ? bus.relu_en : relu_lat;
      last     = (cnt == n_eff - CNT_W'(1));
      stall    = last && out_valid_q && !bus.out_ready;
      ready    = !bus.flush && !stall;
      accept   = bus.in_valid && ready;
      load     = accept && last;
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         n_lat       <= '0;
         relu_lat    <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (bus.flush) begin
         cnt         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
            if (first) begin
               n_lat    <= n_in;
               relu_lat <= bus.relu_en;
            end
         end
         if (load)
            out_valid_q <= 1'b1;
         else if (out_valid_q && bus.out_ready)
            out_valid_q <= 1'b0;
      end
   end

   localparam logic signed [ACC_WIDTH:0]    MAXV = (ACC_WIDTH+1)'((1 << (BIT_WIDTH-1)) - 1);
   localparam logic signed [ACC_WIDTH:0]    MINV = ~MAXV;
   localparam logic signed [BIT_WIDTH-1:0]  YMAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
   localparam logic signed [BIT_WIDTH-1:0]  YMIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic signed [BIT_WIDTH-1:0]  x_l;
         logic signed [BIAS_WIDTH-1:0] b_l;
         logic signed [ACC_WIDTH-1:0]  acc;
         logic signed [ACC_WIDTH-1:0]  sum;
         logic signed [ACC_WIDTH:0]    ext;
         logic signed [ACC_WIDTH:0]    rnd;
         logic signed [BIT_WIDTH-1:0]  clamp;
         logic signed [BIT_WIDTH-1:0]  y_d;
         logic signed [BIT_WIDTH-1:0]  y_q;
         logic                         sat_d;
         logic                         sat_q;

         assign x_l = bus.x_in[gi*BIT_WIDTH +: BIT_WIDTH];
         assign b_l = bus.bias_in[gi*BIAS_WIDTH +: BIAS_WIDTH];

         always_comb begin
            if (first)
               sum = {{(ACC_WIDTH-BIT_WIDTH){x_l[BIT_WIDTH-1]}}, x_l}
                   + {{(ACC_WIDTH-BIAS_WIDTH){b_l[BIAS_WIDTH-1]}}, b_l};
            else
               sum = acc + {{(ACC_WIDTH-BIT_WIDTH){x_l[BIT_WIDTH-1]}}, x_l};
            ext = {sum[ACC_WIDTH-1], sum};
         end

         // One extra bit of headroom keeps the half-LSB add from wrapping.
         if (SHIFT == 0) begin : g_round_off
            assign rnd = ext;
         end else begin : g_round_on
            localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (SHIFT-1);
            assign rnd = (ext + HALF) >>> SHIFT;
         end

         always_comb begin
            clamp = rnd[BIT_WIDTH-1:0];
            sat_d = 1'b0;
            if (rnd > MAXV) begin
               clamp = YMAX;
               sat_d = 1'b1;
            end else if (rnd < MINV) begin
               clamp = YMIN;
               sat_d = 1'b1;
            end
            y_d = (relu_eff && clamp[BIT_WIDTH-1]) ? '0 : clamp;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc   <= '0;
               y_q   <= '0;
               sat_q <= 1'b0;
            end else begin
               if (accept)
                  acc <= sum;
               if (load) begin
                  y_q   <= y_d;
                  sat_q <= sat_d;
               end
            end
         end

         assign bus.y_out[gi*BIT_WIDTH +: BIT_WIDTH] = y_q;
         assign bus.sat_flag[gi]                     = sat_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_acc_bank_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_acc_bank_sat                                                   |
// | Brief  : Directed self-checking bench for acc_bank_sat (SHIFT=0 and 2).    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_acc_bank_sat;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   acc_bank_sat_if #(.LANES(4), .BIT_WIDTH(12), .BIAS_WIDTH(12), .CNT_W(6)) ifc0 ();
   acc_bank_sat_if #(.LANES(4), .BIT_WIDTH(12), .BIAS_WIDTH(12), .CNT_W(6)) ifc2 ();

   acc_bank_sat #(.SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
   acc_bank_sat #(.SHIFT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

   function automatic logic [47:0] pk(input int a, input int b, input int c, input int d);
      return {12'(d), 12'(c), 12'(b), 12'(a)};
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic v, input logic [47:0] x, input logic [47:0] b,
                       input logic [5:0] n, input logic relu);
      ifc0.in_valid = v;
      ifc0.x_in     = x;
      ifc0.bias_in  = b;
      ifc0.num_chn  = n;
      ifc0.relu_en  = relu;
      ifc0.flush    = 1'b0;
   endtask

   initial begin
      drv0(1'b0, '0, '0, 6'd0, 1'b0);
      ifc0.out_ready = 1'b1;
      ifc2.in_valid  = 1'b0;
      ifc2.x_in      = '0;
      ifc2.bias_in   = '0;
      ifc2.num_chn   = 6'd1;
      ifc2.relu_en   = 1'b0;
      ifc2.flush     = 1'b0;
      ifc2.out_ready = 1'b1;
      #12 rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_valid", 48'(ifc0.out_valid), 48'd0);
      chk("rst_y",     ifc0.y_out,          48'd0);
      chk("rst_sat",   48'(ifc0.sat_flag),  48'd0);
      chk("rst_ready", 48'(ifc0.in_ready),  48'd1);
      chk("rst_valid2", 48'(ifc2.out_valid), 48'd0);

      // N=3 basic sum with bias
      drv0(1'b1, pk(100, -1, 0, 0), pk(10, -5, 0, 0), 6'd3, 1'b0);
      tick();
      chk("n3_b1_valid", 48'(ifc0.out_valid), 48'd0);
      drv0(1'b1, pk(200, -1, 0, 0), pk(10, -5, 0, 0), 6'd0, 1'b0);
      tick();
      chk("n3_b2_valid", 48'(ifc0.out_valid), 48'd0);
      drv0(1'b1, pk(300, -1, 0, 0), pk(10, -5, 0, 0), 6'd0, 1'b0);
      tick();
      chk("n3_valid", 48'(ifc0.out_valid), 48'd1);
      chk("n3_y",     ifc0.y_out,          pk(610, -8, 0, 0));
      chk("n3_sat",   48'(ifc0.sat_flag),  48'd0);
      drv0(1'b0, '0, '0, 6'd0, 1'b0);
      tick();
      chk("n3_valid_drop", 48'(ifc0.out_valid), 48'd0);

      // Saturation, no ReLU
      drv0(1'b1, pk(2000, -2000, -3, 0), '0, 6'd2, 1'b0);
      tick();
      tick();
      chk("sat_valid", 48'(ifc0.out_valid), 48'd1);
      chk("sat_y",     ifc0.y_out,          pk(2047, -2048, -6, 0));
      chk("sat_flag",  48'(ifc0.sat_flag),  48'b0011);

      // Saturation with ReLU latched on first beat only
      drv0(1'b1, pk(2000, -2000, -3, 0), '0, 6'd2, 1'b1);
      tick();
      drv0(1'b1, pk(2000, -2000, -3, 0), '0, 6'd2, 1'b0);
      tick();
      chk("relu_valid", 48'(ifc0.out_valid), 48'd1);
      chk("relu_y",     ifc0.y_out,          pk(2047, 0, 0, 0));
      chk("relu_sat",   48'(ifc0.sat_flag),  48'b0011);
      drv0(1'b0, '0, '0, 6'd0, 1'b0);
      tick();

      // Rounding shift on the SHIFT=2 instance
      ifc2.in_valid = 1'b1;
      ifc2.x_in     = pk(6, 5, -6, -7);
      tick();
      chk("sh_valid", 48'(ifc2.out_valid), 48'd1);
      chk("sh_y",     ifc2.y_out,          pk(2, 1, -1, -2));
      chk("sh_sat",   48'(ifc2.sat_flag),  48'd0);
      ifc2.x_in = pk(2, -2, 1, -1);
      tick();
      chk("sh_valid2", 48'(ifc2.out_valid), 48'd1);
      chk("sh_y2",     ifc2.y_out,          pk(1, 0, 0, 0));
      ifc2.in_valid = 1'b0;

      // Backpressure: A held, B last beat stalled then merged with A handshake
      ifc0.out_ready = 1'b0;
      drv0(1'b1, pk(1, 0, 0, 0), '0, 6'd2, 1'b0);
      tick();
      drv0(1'b1, pk(2, 0, 0, 0), '0, 6'd2, 1'b0);
      tick();
      chk("bp_a_valid", 48'(ifc0.out_valid), 48'd1);
      chk("bp_a_y",     ifc0.y_out,          pk(3, 0, 0, 0));
      drv0(1'b1, pk(10, 0, 0, 0), '0, 6'd2, 1'b0);
      #1;
      chk("bp_b1_ready", 48'(ifc0.in_ready), 48'd1);
      tick();
      drv0(1'b1, pk(20, 0, 0, 0), '0, 6'd2, 1'b0);
      #1;
      chk("bp_b2_stall", 48'(ifc0.in_ready), 48'd0);
      tick();
      chk("bp_hold_valid", 48'(ifc0.out_valid), 48'd1);
      chk("bp_hold_y",     ifc0.y_out,          pk(3, 0, 0, 0));
      tick();
      ifc0.out_ready = 1'b1;
      #1;
      chk("bp_b2_ready", 48'(ifc0.in_ready), 48'd1);
      tick();
      chk("bp_b_valid", 48'(ifc0.out_valid), 48'd1);
      chk("bp_b_y",     ifc0.y_out,          pk(30, 0, 0, 0));
      drv0(1'b0, '0, '0, 6'd0, 1'b0);
      tick();
      chk("bp_b_drop", 48'(ifc0.out_valid), 48'd0);

      // N=0 acts as N=1
      drv0(1'b1, pk(7, 0, 0, 0), pk(1, 0, 0, 0), 6'd0, 1'b0);
      tick();
      chk("n0_valid", 48'(ifc0.out_valid), 48'd1);
      chk("n0_y",     ifc0.y_out,          pk(8, 0, 0, 0));

      // N=40 clamps to 32 beats
      drv0(1'b1, pk(1, 0, 0, 0), '0, 6'd40, 1'b0);
      for (int i = 0; i < 31; i++) tick();
      chk("n40_31_valid", 48'(ifc0.out_valid), 48'd0);
      tick();
      chk("n40_valid", 48'(ifc0.out_valid), 48'd1);
      chk("n40_y",     ifc0.y_out,          pk(32, 0, 0, 0));

      // Asynchronous reset mid-group
      ifc0.out_ready = 1'b0;
      drv0(1'b1, pk(1, 0, 0, 0), '0, 6'd5, 1'b0);
      tick();
      tick();
      drv0(1'b0, '0, '0, 6'd0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 48'(ifc0.out_valid), 48'd0);
      chk("arst_y",     ifc0.y_out,          48'd0);
      chk("arst_sat",   48'(ifc0.sat_flag),  48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drv0(1'b1, pk(5, 0, 0, 0), pk(2, 0, 0, 0), 6'd1, 1'b0);
      tick();
      chk("arst_next_y", ifc0.y_out, pk(7, 0, 0, 0));

      // Flush mid-group: next beat is a fresh first beat
      drv0(1'b1, pk(100, 0, 0, 0), pk(50, 0, 0, 0), 6'd3, 1'b0);
      tick();
      tick();
      ifc0.flush = 1'b1;
      #1;
      chk("flush_ready", 48'(ifc0.in_ready), 48'd0);
      tick();
      chk("flush_valid", 48'(ifc0.out_valid), 48'd0);
      drv0(1'b1, pk(4, 0, 0, 0), pk(3, 0, 0, 0), 6'd1, 1'b0);
      tick();
      chk("flush_next_valid", 48'(ifc0.out_valid), 48'd1);
      chk("flush_next_y",     ifc0.y_out,          pk(7, 0, 0, 0));
      drv0(1'b0, '0, '0, 6'd0, 1'b0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
